// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous memory between
// the instruction-fetch port and the data port, one access in flight at a time.
module mem_port_arbiter #(
    parameter int WORD_LEN = 32,
    parameter int MEM_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch port
    input  logic                i_req,
    input  logic [WORD_LEN-1:0] i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [WORD_LEN-1:0] i_rdata,
    // data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [WORD_LEN-1:0] d_addr,
    input  logic [WORD_LEN-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [WORD_LEN-1:0] d_rdata,
    // memory macro
    output logic                m_en,
    output logic                m_we,
    output logic [WORD_LEN-1:0] m_addr,
    output logic [WORD_LEN-1:0] m_wdata,
    input  logic [WORD_LEN-1:0] m_rdata,
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic       OWN_I    = 1'b0;
    localparam logic       OWN_D    = 1'b1;
    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

    state_t              r_state;
    logic                r_prio;
    logic                r_owner;
    logic                r_we;
    logic [2:0]          r_cnt;
    logic [WORD_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [WORD_LEN-1:0] r_i_rdata;
    logic [WORD_LEN-1:0] r_d_rdata;
    logic                r_i_gnt;
    logic                r_d_gnt;
    logic                r_i_rvalid;
    logic                r_d_rvalid;
    logic                r_m_en;
    logic                r_m_we;
    logic                r_busy;

    // Data port wins when it is the only requester or when it holds priority.
    logic w_any_req;
    logic w_pick_d;
    assign w_any_req = i_req | d_req;
    assign w_pick_d  = d_req & (~i_req | (r_prio == OWN_D));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prio     <= OWN_I;
            r_owner    <= OWN_I;
            r_we       <= 1'b0;
            r_cnt      <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_i_gnt    <= 1'b0;
            r_d_gnt    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_m_en     <= 1'b0;
            r_m_we     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick_d;
                        r_prio  <= ~w_pick_d;
                        r_we    <= w_pick_d & d_we;
                        r_addr  <= w_pick_d ? d_addr : i_addr;
                        if (w_pick_d) begin
                            r_wdata <= d_wdata;
                        end
                        // Strobes are registered so they coincide with ISSUE.
                        r_m_en  <= 1'b1;
                        r_m_we  <= w_pick_d & d_we;
                        r_i_gnt <= ~w_pick_d;
                        r_d_gnt <= w_pick_d;
                        r_busy  <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= LAT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        if (r_owner == OWN_D) begin
                            r_d_rdata  <= m_rdata;
                            r_d_rvalid <= 1'b1;
                        end else begin
                            r_i_rdata  <= m_rdata;
                            r_i_rvalid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_gnt    = r_i_gnt;
    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_gnt    = r_d_gnt;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;
    assign m_en     = r_m_en;
    assign m_we     = r_m_we;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign busy     = r_busy;

endmodule
